// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update controller: packet layout and op encoding.
// Packet layout, MSB first: pc, target, index, op, orien, push_ras, pop_ras.
package btb_pkg;

    localparam int PKT_W     = 75;
    localparam int PC_LSB    = 43;
    localparam int TGT_LSB   = 11;
    localparam int IDX_LSB   = 6;
    localparam int OP_LSB    = 3;
    localparam int ORIEN_BIT = 2;
    localparam int PUSH_BIT  = 1;
    localparam int POP_BIT   = 0;

    localparam logic [2:0] OP_NONE      = 3'd0;
    localparam logic [2:0] OP_ADD       = 3'd1;
    localparam logic [2:0] OP_DEL       = 3'd2;
    localparam logic [2:0] OP_PRE_ERR   = 3'd3;
    localparam logic [2:0] OP_PRE_RIGHT = 3'd4;
    localparam logic [2:0] OP_TGT_ERR   = 3'd5;

    typedef logic [PKT_W-1:0] btb_pkt_t;

    // A packet is worth queueing if it carries a real BTB op or any RAS action.
    function automatic logic pkt_keep(input btb_pkt_t pkt);
        logic [2:0] op;
        op = pkt[OP_LSB +: 3];
        return (op >= OP_ADD && op <= OP_TGT_ERR) || pkt[PUSH_BIT] || pkt[POP_BIT];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update-packet FIFO with combinational head read and a registered occupancy count.
// Pointers wrap naturally modulo DEPTH (power of two); flush empties it in one edge.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 75,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [PKT_W-1:0] push_data,
    input  logic             pop,
    output logic [PKT_W-1:0] head_data,
    output logic [AW:0]      count,
    output logic             full
);

    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: arbitrates two requesters into a FIFO and issues one
// decoded update per cycle, leaving a one-cycle gap after every add.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [PKT_W-1:0] req0_pkt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [PKT_W-1:0] req1_pkt,
    output logic             operate_en,
    output logic [31:0]      operate_pc,
    output logic [31:0]      right_target,
    output logic [4:0]       operate_index,
    output logic             add_entry,
    output logic             delete_entry,
    output logic             pre_error,
    output logic             pre_right,
    output logic             target_error,
    output logic             right_orien,
    output logic             push_ras,
    output logic             pop_ras,
    output logic [2:0]       occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [SW-1:0] r_starve;
    logic          w_boost;
    logic          w_full;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_push;
    logic          w_pop;
    btb_pkt_t      w_in_pkt;
    btb_pkt_t      w_head;
    logic [2:0]    w_op;
    logic [AW:0]   w_count;

    assign w_boost    = (r_starve == SW'(STARVE_MAX));
    assign req0_ready = !w_full && !flush && !w_boost;
    assign req1_ready = !w_full && !flush && (!req0_valid || w_boost);
    assign w_grant0   = req0_valid && req0_ready;
    assign w_grant1   = req1_valid && req1_ready;
    assign w_in_pkt   = w_grant1 ? req1_pkt : req0_pkt;
    // Handshake still completes for dropped packets; they just never reach the FIFO.
    assign w_push     = (w_grant0 || w_grant1) && pkt_keep(w_in_pkt);
    assign w_pop      = (r_state == S_ISSUE) && !flush;
    assign w_op       = w_head[OP_LSB +: 3];
    assign occupancy  = 3'(w_count);

    btb_upd_fifo #(
        .DEPTH (DEPTH),
        .PKT_W (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_in_pkt),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (flush || w_grant1 || !req1_valid) begin
            r_starve <= '0;
        end else if (w_grant0 && !w_boost) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Entries pushed on the current edge are not yet counted, which keeps the
    // accept-to-issue latency at two cycles whenever the queue runs dry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_count != '0) w_state_next = S_ISSUE;
            S_ISSUE: begin
                if (w_op == OP_ADD)                 w_state_next = S_GAP;
                else if (w_count > (AW+1)'(1))      w_state_next = S_ISSUE;
                else                                w_state_next = S_IDLE;
            end
            S_GAP:   w_state_next = (w_count != '0) ? S_ISSUE : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            operate_en    <= 1'b0;
            operate_pc    <= '0;
            right_target  <= '0;
            operate_index <= '0;
            add_entry     <= 1'b0;
            delete_entry  <= 1'b0;
            pre_error     <= 1'b0;
            pre_right     <= 1'b0;
            target_error  <= 1'b0;
            right_orien   <= 1'b0;
            push_ras      <= 1'b0;
            pop_ras       <= 1'b0;
        end else begin
            operate_en    <= w_pop;
            operate_pc    <= w_pop ? w_head[PC_LSB +: 32]  : '0;
            right_target  <= w_pop ? w_head[TGT_LSB +: 32] : '0;
            operate_index <= w_pop ? w_head[IDX_LSB +: 5]  : '0;
            add_entry     <= w_pop && (w_op == OP_ADD);
            delete_entry  <= w_pop && (w_op == OP_DEL);
            pre_error     <= w_pop && (w_op == OP_PRE_ERR);
            pre_right     <= w_pop && (w_op == OP_PRE_RIGHT);
            target_error  <= w_pop && (w_op == OP_TGT_ERR);
            right_orien   <= w_pop && w_head[ORIEN_BIT];
            push_ras      <= w_pop && w_head[PUSH_BIT];
            pop_ras       <= w_pop && w_head[POP_BIT];
        end
    end

endmodule
